// File: rtl/ser_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// ser_frame_ctrl_if
// Sample-word handshake between the radio sample capture (master) and the
// frame scheduler (slave).
//   DIN        sample word, WORD_W bits
//   DIN_VALID  DIN carries a sample this cycle
//   DIN_READY  scheduler FIFO can accept a word this cycle
// ---------------------------------------------------------------------------
interface ser_frame_ctrl_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] DIN;
    logic              DIN_VALID;
    logic              DIN_READY;

    modport master (output DIN, output DIN_VALID, input  DIN_READY);
    modport slave  (input  DIN, input  DIN_VALID, output DIN_READY);
endinterface

// File: rtl/ser_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ser_frame_ctrl
// Frame scheduler for the radio serial link. Buffers sample words in a
// 2-entry FIFO and emits SYNC_WORD followed by FRAME_LEN sample words, MSB
// first, one bit per SYS_CLK. A missing sample is replaced by FILL_WORD.
// Ports:
//   SYS_CLK    bit clock, all logic on rising edge
//   RST        synchronous reset, active high
//   EN         run enable, looked at only in IDLE and at frame end
//   din_if     sample-word handshake (slave side)
//   DATA_OUT   serial bit (registered)
//   SYNC       high while a header bit is on DATA_OUT (registered)
//   BUSY       high while a frame is being sent
//   OVERFLOW   sticky: a word was offered while the FIFO was full
//   UNDERRUN   sticky: FILL_WORD was sent at least once
//   FRAME_CNT  completed frames, wraps
// ---------------------------------------------------------------------------
module ser_frame_ctrl #(
    parameter int                WORD_W    = 8,
    parameter int                FRAME_LEN = 64,
    parameter logic [WORD_W-1:0] SYNC_WORD = 8'hA5,
    parameter logic [WORD_W-1:0] FILL_WORD = 8'h00
) (
    input  logic                   SYS_CLK,
    input  logic                   RST,
    input  logic                   EN,
    ser_frame_ctrl_if.slave        din_if,
    output logic                   DATA_OUT,
    output logic                   SYNC,
    output logic                   BUSY,
    output logic                   OVERFLOW,
    output logic                   UNDERRUN,
    output logic [15:0]            FRAME_CNT
);
    localparam int BI_W = $clog2(WORD_W);
    localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BI_W-1:0] LAST_BIT  = BI_W'(WORD_W - 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [BI_W-1:0]   bit_idx_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic              data_out_q, sync_q, busy_q, overflow_q, underrun_q;
    logic [15:0]       frame_cnt_q;

    // 2-entry FIFO storage and pointers
    logic [WORD_W-1:0] mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    logic              ready;
    logic              push;
    logic              load_word;
    logic              pop;
    logic              fifo_empty;
    logic [WORD_W-1:0] next_word;

    // READY comes from the stored count only: a pop in the same cycle does
    // not free a slot early.
    assign ready            = (count_q != 2'd2);
    assign din_if.DIN_READY = ready;
    assign push             = din_if.DIN_VALID && ready;
    assign fifo_empty       = (count_q == 2'd0);

    // A new sample word is needed on the cycle the current word's last bit is
    // on the line: end of header, or end of a data word that is not the last.
    always_comb begin
        load_word = 1'b0;
        if (bit_idx_q == LAST_BIT) begin
            if (state_q == HDR)
                load_word = 1'b1;
            else if (state_q == DATA && word_cnt_q < LAST_WORD)
                load_word = 1'b1;
        end
        pop       = load_word && !fifo_empty;
        next_word = fifo_empty ? FILL_WORD : mem_q[rd_ptr_q];
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_mem
            always_ff @(posedge SYS_CLK) begin
                if (push && wr_ptr_q == 1'(gi))
                    mem_q[gi] <= din_if.DIN;
            end
        end
    endgenerate

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            word_cnt_q  <= '0;
            data_out_q  <= 1'b0;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            if (din_if.DIN_VALID && !ready) overflow_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    data_out_q <= 1'b0;
                    sync_q     <= 1'b0;
                    if (EN && !fifo_empty) begin
                        shreg_q    <= SYNC_WORD;
                        data_out_q <= SYNC_WORD[WORD_W-1];
                        sync_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        bit_idx_q  <= '0;
                        state_q    <= HDR;
                    end
                end
                HDR, DATA: begin
                    if (load_word) begin
                        shreg_q    <= next_word;
                        data_out_q <= next_word[WORD_W-1];
                        sync_q     <= 1'b0;
                        bit_idx_q  <= '0;
                        word_cnt_q <= (state_q == HDR) ? '0 : word_cnt_q + 1'b1;
                        if (fifo_empty) underrun_q <= 1'b1;
                        state_q    <= DATA;
                    end else if (bit_idx_q == LAST_BIT) begin
                        // Last bit of the last data word: frame done.
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        bit_idx_q   <= '0;
                        if (EN) begin
                            // Back-to-back header, even with an empty FIFO.
                            shreg_q    <= SYNC_WORD;
                            data_out_q <= SYNC_WORD[WORD_W-1];
                            sync_q     <= 1'b1;
                            state_q    <= HDR;
                        end else begin
                            data_out_q <= 1'b0;
                            sync_q     <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end else begin
                        shreg_q    <= shreg_q << 1;
                        data_out_q <= shreg_q[WORD_W-2];
                        bit_idx_q  <= bit_idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DATA_OUT  = data_out_q;
    assign SYNC      = sync_q;
    assign BUSY      = busy_q;
    assign OVERFLOW  = overflow_q;
    assign UNDERRUN  = underrun_q;
    assign FRAME_CNT = frame_cnt_q;
endmodule
